rx_iq_buffer: RTL and testbench

Elastic buffer between the RX decimation chain and the STM32 parallel-bus interface. It accepts RX1/RX2 I/Q sample sets from the decimators and stores them in a small FIFO. It presents the oldest unread set on show-ahead output registers, and advances one set per rising edge of the bus interface's `IQ_RX_READ_CLK` strobe. It also raises sticky overrun and underrun flags so that the interface can report data loss to the MCU.

---
 rtl/rx_iq_buffer.sv | 146 ++++++++++++++
 tb/tb_rx_iq_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_buffer.sv
// rx_iq_buffer
// Elastic buffer between the RX decimation chain and the STM32 parallel-bus
// interface. Decimator sample sets (RX1/RX2 I/Q) go into a small FIFO. The
// oldest unread set sits in a show-ahead output stage, and one rising edge of
// IQ_RX_READ_CLK advances the output stage by one set. Sticky overrun and
// underrun flags report data loss to the MCU.
//
// Ports:
//   clk_in          interface clock, all logic on its rising edge
//   reset           synchronous active-high reset
//   in_valid        one-cycle strobe, new set on in_rx*_*
//   in_rx1_i/q, in_rx2_i/q   24-bit signed decimator outputs
//   IQ_RX_READ_REQ  reader active (qualifies overrun flagging only)
//   IQ_RX_READ_CLK  pop strobe, rising edge consumes the presented set
//   overrun_clear   one-cycle pulse clearing both sticky flags
//   RX1_I/Q, RX2_I/Q  presented (show-ahead) sample set
//   fifo_level      entries in FIFO storage, output stage excluded
//   iq_overrun      sticky: set dropped while the reader was active
//   iq_underrun     sticky: pop arrived with no fresh set presented

module rx_iq_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [23:0]  in_rx1_i,
    input  logic signed [23:0]  in_rx1_q,
    input  logic signed [23:0]  in_rx2_i,
    input  logic signed [23:0]  in_rx2_q,
    input  logic                IQ_RX_READ_REQ,
    input  logic                IQ_RX_READ_CLK,
    input  logic                overrun_clear,
    output logic signed [23:0]  RX1_I,
    output logic signed [23:0]  RX1_Q,
    output logic signed [23:0]  RX2_I,
    output logic signed [23:0]  RX2_Q,
    output logic [ADDR_W:0]     fifo_level,
    output logic                iq_overrun,
    output logic                iq_underrun
);

    logic [95:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count;
    logic            out_full;
    logic            rc_prev;

    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic            do_read;
    logic            do_write;
    logic            overrun_evt;
    logic            underrun_evt;
    logic [95:0]     head;

    // Event decoding. A pop from the reader frees the output stage in the
    // same cycle, so a full FIFO can still accept a write when the head is
    // moved out by that pop.
    always_comb begin
        pop          = IQ_RX_READ_CLK & ~rc_prev;
        fifo_empty   = (count == '0);
        fifo_full    = (count == (ADDR_W+1)'(DEPTH));
        do_read      = !fifo_empty && (!out_full || pop);
        do_write     = in_valid && (!fifo_full || do_read);
        overrun_evt  = in_valid && fifo_full && !do_read && IQ_RX_READ_REQ;
        underrun_evt = pop && !out_full;
        head         = mem[rd_ptr[ADDR_W-1:0]];
    end

    // Sample storage has no reset. The pointers and count define which
    // entries are valid, so the stale contents left after a reset are never
    // presented.
    always_ff @(posedge clk_in) begin
        if (!reset && do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {in_rx1_i, in_rx1_q, in_rx2_i, in_rx2_q};
        end
    end

    // Pointers and occupancy. Both pointers carry one extra bit, and the low
    // ADDR_W bits address storage, so wrapping the full width wraps modulo
    // DEPTH.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Show-ahead output stage. A pop that finds the FIFO empty only marks the
    // stage as stale. The last set stays on the pins, so the bus never sees
    // garbage.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            RX1_I    <= '0;
            RX1_Q    <= '0;
            RX2_I    <= '0;
            RX2_Q    <= '0;
            out_full <= 1'b0;
        end else if (do_read) begin
            {RX1_I, RX1_Q, RX2_I, RX2_Q} <= head;
            out_full <= 1'b1;
        end else if (pop) begin
            out_full <= 1'b0;
        end
    end

    // Strobe edge detector. Reset loads 1, so a strobe that is already high
    // when reset is released is not taken as a pop.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rc_prev <= 1'b1;
        end else begin
            rc_prev <= IQ_RX_READ_CLK;
        end
    end

    // Sticky flags. A new event in the same cycle as the clear pulse keeps
    // the flag set, so the event is not lost.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            iq_overrun  <= 1'b0;
            iq_underrun <= 1'b0;
        end else begin
            if (overrun_evt)        iq_overrun <= 1'b1;
            else if (overrun_clear) iq_overrun <= 1'b0;
            if (underrun_evt)       iq_underrun <= 1'b1;
            else if (overrun_clear) iq_underrun <= 1'b0;
        end
    end

    assign fifo_level = count;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// tb_rx_iq_buffer
// Directed testbench for rx_iq_buffer (DEPTH=16). Inputs change on the
// falling edge and outputs are sampled on the falling edge. Every expected
// value is written out by hand in the step sequence below.

module tb_rx_iq_buffer;

    logic               clk_in = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [23:0] in_rx1_i = '0;
    logic signed [23:0] in_rx1_q = '0;
    logic signed [23:0] in_rx2_i = '0;
    logic signed [23:0] in_rx2_q = '0;
    logic               IQ_RX_READ_REQ = 1'b0;
    logic               IQ_RX_READ_CLK = 1'b0;
    logic               overrun_clear = 1'b0;
    logic signed [23:0] RX1_I;
    logic signed [23:0] RX1_Q;
    logic signed [23:0] RX2_I;
    logic signed [23:0] RX2_Q;
    logic [4:0]         fifo_level;
    logic               iq_overrun;
    logic               iq_underrun;

    int pass_count = 0;
    int check_count = 0;

    rx_iq_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_rx1_i       (in_rx1_i),
        .in_rx1_q       (in_rx1_q),
        .in_rx2_i       (in_rx2_i),
        .in_rx2_q       (in_rx2_q),
        .IQ_RX_READ_REQ (IQ_RX_READ_REQ),
        .IQ_RX_READ_CLK (IQ_RX_READ_CLK),
        .overrun_clear  (overrun_clear),
        .RX1_I          (RX1_I),
        .RX1_Q          (RX1_Q),
        .RX2_I          (RX2_I),
        .RX2_Q          (RX2_Q),
        .fifo_level     (fifo_level),
        .iq_overrun     (iq_overrun),
        .iq_underrun    (iq_underrun)
    );

    // 10 ns clock
    always #5 clk_in = ~clk_in;

    // Advance n falling edges
    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Set k: rx1_i=k, rx1_q=k+0x100, rx2_i=k+0x200, rx2_q=k+0x300
    function automatic logic [95:0] set_of(input logic [23:0] k);
        return {k, k + 24'h100, k + 24'h200, k + 24'h300};
    endfunction

    // Present one sample set on the inputs with a one-cycle in_valid strobe
    task automatic applyStimulus(input logic [95:0] s);
        {in_rx1_i, in_rx1_q, in_rx2_i, in_rx2_q} = s;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
    endtask

    // One comparison: count it, assert equality, report on mismatch
    task automatic checkOutput(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        checkOutput("reset_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, 96'h0);
        checkOutput("reset_level", 96'(fifo_level), 96'd0);
        checkOutput("reset_flags", 96'({iq_overrun, iq_underrun}), 96'd0);

        // First set latency: visible after two edges
        {in_rx1_i, in_rx1_q, in_rx2_i, in_rx2_q} = {24'h1, 24'h2, 24'h3, 24'h4};
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        checkOutput("lat_edge1_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, 96'h0);
        checkOutput("lat_edge1_level", 96'(fifo_level), 96'd1);
        step(1);
        checkOutput("lat_out", {RX1_I, RX1_Q, RX2_I, RX2_Q},
                    {24'h1, 24'h2, 24'h3, 24'h4});
        checkOutput("lat_level", 96'(fifo_level), 96'd0);

        // Five sets, then five pops with period 4
        do_reset();
        for (int k = 1; k <= 5; k++) applyStimulus(set_of(24'(k)));
        step(1);
        checkOutput("pop0_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_of(24'd1));
        checkOutput("pop0_level", 96'(fifo_level), 96'd4);
        for (int p = 1; p <= 5; p++) begin
            IQ_RX_READ_CLK = 1'b1;
            step(2);
            checkOutput($sformatf("pop%0d_out", p), {RX1_I, RX1_Q, RX2_I, RX2_Q},
                        set_of(24'((p < 5) ? p + 1 : 5)));
            checkOutput($sformatf("pop%0d_level", p), 96'(fifo_level),
                        96'((p < 5) ? 4 - p : 0));
            IQ_RX_READ_CLK = 1'b0;
            step(2);
        end
        checkOutput("pop_flags", 96'({iq_overrun, iq_underrun}), 96'd0);

        // Pop with nothing presented: underrun, outputs hold set 5
        IQ_RX_READ_CLK = 1'b1;
        step(2);
        IQ_RX_READ_CLK = 1'b0;
        checkOutput("underrun_flag", 96'(iq_underrun), 96'd1);
        checkOutput("underrun_hold", {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_of(24'd5));
        checkOutput("underrun_level", 96'(fifo_level), 96'd0);
        overrun_clear = 1'b1;
        step(1);
        overrun_clear = 1'b0;
        checkOutput("underrun_cleared", 96'({iq_overrun, iq_underrun}), 96'd0);

        // REQ=1, 18 writes: 17 kept (1 presented + 16 stored), 18th overruns
        do_reset();
        IQ_RX_READ_REQ = 1'b1;
        for (int k = 1; k <= 17; k++) applyStimulus(set_of(24'(k)));
        checkOutput("full17_level", 96'(fifo_level), 96'd16);
        checkOutput("full17_overrun", 96'(iq_overrun), 96'd0);
        applyStimulus(set_of(24'd18));
        checkOutput("full18_overrun", 96'(iq_overrun), 96'd1);
        checkOutput("full18_level", 96'(fifo_level), 96'd16);
        checkOutput("full18_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_of(24'd1));
        // Clear coinciding with a new drop: the set wins
        overrun_clear = 1'b1;
        applyStimulus(set_of(24'd19));
        overrun_clear = 1'b0;
        checkOutput("clr_vs_set", 96'(iq_overrun), 96'd1);
        overrun_clear = 1'b1;
        step(1);
        overrun_clear = 1'b0;
        checkOutput("overrun_cleared", 96'(iq_overrun), 96'd0);

        // REQ=0: drops are silent
        do_reset();
        IQ_RX_READ_REQ = 1'b0;
        for (int k = 1; k <= 18; k++) applyStimulus(set_of(24'(k)));
        checkOutput("silent_level", 96'(fifo_level), 96'd16);
        checkOutput("silent_overrun", 96'(iq_overrun), 96'd0);
        // Full: write and pop in the same cycle, both happen, no overrun
        IQ_RX_READ_REQ = 1'b1;
        IQ_RX_READ_CLK = 1'b1;
        applyStimulus(set_of(24'h40));
        checkOutput("fullrw_level", 96'(fifo_level), 96'd16);
        checkOutput("fullrw_overrun", 96'(iq_overrun), 96'd0);
        checkOutput("fullrw_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_of(24'd2));
        IQ_RX_READ_CLK = 1'b0;
        IQ_RX_READ_REQ = 1'b0;
        step(1);

        // Strobe held high 10 cycles: exactly one advance
        do_reset();
        for (int k = 1; k <= 3; k++) applyStimulus(set_of(24'(k)));
        step(1);
        checkOutput("hold_pre_level", 96'(fifo_level), 96'd2);
        IQ_RX_READ_CLK = 1'b1;
        step(10);
        checkOutput("hold_level", 96'(fifo_level), 96'd1);
        checkOutput("hold_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_of(24'd2));
        IQ_RX_READ_CLK = 1'b0;
        step(1);

        // Reset mid-operation with the strobe high
        do_reset();
        for (int k = 1; k <= 8; k++) applyStimulus(set_of(24'(k)));
        checkOutput("midrst_pre_level", 96'(fifo_level), 96'd7);
        reset = 1'b1;
        IQ_RX_READ_CLK = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        checkOutput("midrst_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, 96'h0);
        checkOutput("midrst_level", 96'(fifo_level), 96'd0);
        checkOutput("midrst_no_pop", 96'(iq_underrun), 96'd0);
        applyStimulus(set_of(24'h55));
        step(1);
        checkOutput("midrst_write_out", {RX1_I, RX1_Q, RX2_I, RX2_Q}, set_of(24'h55));
        IQ_RX_READ_CLK = 1'b0;
        step(1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
